// File: rtl/datamover_pkg.sv
// rtl/datamover_pkg.sv - shared read/write datamover types
package datamover_pkg;

  typedef enum logic [0:0] {
    ISSUE = 1'b0,
    WAIT  = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_WAIT = 2'd2
  } wr_state_e;

endpackage

// File: rtl/datamover_sync_fifo.sv
// rtl/datamover_sync_fifo.sv - single-clock FIFO holding pending datamover requests
module datamover_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arbiter2bram_datamover.sv
// rtl/arbiter2bram_datamover.sv - queues BRAM reads and issues them one at a time to an arbiter
module arbiter2bram_datamover
  import datamover_pkg::*;
#(
  parameter int BRAM_ADDRWIDTH = 10,
  parameter int DATAWIDTH      = 1024,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      full_o,
  output logic                      done_o,
  output logic                      err_o,
  input  logic [BRAM_ADDRWIDTH-1:0] bram_addr,
  input  logic                      bram_en,
  input  logic                      bram_we,
  output logic [DATAWIDTH-1:0]      bram_rddata,
  output logic                      bram_rdvalid,
  output logic                      rd_req,
  input  logic                      rd_gnt,
  output logic [BRAM_ADDRWIDTH-1:0] rd_addr,
  input  logic [DATAWIDTH-1:0]      rd_data,
  input  logic                      rd_valid
);

  rd_state_e                 state_q;
  rd_state_e                 state_d;
  logic                      push;
  logic                      pop;
  logic                      empty;
  logic [BRAM_ADDRWIDTH-1:0] head;

  assign push = bram_en & ~bram_we & ~full_o;

  datamover_sync_fifo #(
    .WIDTH (BRAM_ADDRWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bram_addr),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ISSUE;
    else        state_q <= state_d;
  end

  // Only one granted read may be outstanding, so requests are masked in WAIT.
  always_comb begin
    state_d = state_q;
    rd_req  = 1'b0;
    rd_addr = '0;
    pop     = 1'b0;
    case (state_q)
      ISSUE: begin
        if (!empty) begin
          rd_req  = 1'b1;
          rd_addr = head;
          if (rd_gnt) begin
            pop     = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (rd_valid) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  // Return data arriving in ISSUE was never asked for: flag it and drop it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_rddata  <= '0;
      bram_rdvalid <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      bram_rdvalid <= (state_q == WAIT) && rd_valid;
      done_o       <= (state_q == WAIT) && rd_valid;
      if ((state_q == WAIT) && rd_valid) bram_rddata <= rd_data;
      if ((state_q == ISSUE) && rd_valid) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arbiter2bram_datamover.sv
// tb/tb_arbiter2bram_datamover.sv - directed self-checking bench for arbiter2bram_datamover
module tb_arbiter2bram_datamover;

  logic        clk;
  logic        rst_n;
  logic        full_o;
  logic        done_o;
  logic        err_o;
  logic [9:0]  bram_addr;
  logic        bram_en;
  logic        bram_we;
  logic [31:0] bram_rddata;
  logic        bram_rdvalid;
  logic        rd_req;
  logic        rd_gnt;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  int n_tests = 0;
  int n_fail  = 0;

  arbiter2bram_datamover #(
    .BRAM_ADDRWIDTH (10),
    .DATAWIDTH      (32),
    .DEPTH          (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .full_o       (full_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .bram_addr    (bram_addr),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .bram_rddata  (bram_rddata),
    .bram_rdvalid (bram_rdvalid),
    .rd_req       (rd_req),
    .rd_gnt       (rd_gnt),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [9:0] a);
    bram_en   = 1'b1;
    bram_we   = 1'b0;
    bram_addr = a;
    tick();
    bram_en   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bram_addr = '0; bram_en = 1'b0; bram_we = 1'b0;
    rd_gnt = 1'b0; rd_data = '0; rd_valid = 1'b0;
    #23;
    check("rst_full", full_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rddata", bram_rddata, 0);
    check("rst_rdvalid", bram_rdvalid, 0);
    check("rst_req", rd_req, 0);
    check("rst_addr", rd_addr, 0);
    rst_n = 1'b1;
    tick();

    // write enable set: must be ignored
    bram_en = 1'b1; bram_we = 1'b1; bram_addr = 10'h3F;
    tick();
    bram_en = 1'b0; bram_we = 1'b0;
    check("we_ignored_req", rd_req, 0);

    // single read
    push_rd(10'h05);
    check("single_req", rd_req, 1);
    check("single_addr", rd_addr, 10'h05);
    rd_gnt = 1'b1;
    tick();
    rd_gnt = 1'b0;
    check("wait_req_low", rd_req, 0);
    check("wait_addr_zero", rd_addr, 0);
    tick();
    tick();
    check("wait_no_rdvalid", bram_rdvalid, 0);
    rd_valid = 1'b1; rd_data = 32'hA5;
    tick();
    rd_valid = 1'b0; rd_data = '0;
    check("single_data", bram_rddata, 32'hA5);
    check("single_rdvalid", bram_rdvalid, 1);
    check("single_done", done_o, 1);
    tick();
    check("single_rdvalid_pulse", bram_rdvalid, 0);
    check("single_done_pulse", done_o, 0);
    check("single_data_hold", bram_rddata, 32'hA5);

    // backpressure / full
    for (int i = 0; i < 5; i++) begin
      push_rd(10'h10 + 10'(i));
      if (i == 2) check("not_full_3", full_o, 0);
      if (i == 3) check("full_after_4", full_o, 1);
      check("bp_req", rd_req, 1);
      check("bp_addr", rd_addr, 10'h10);
    end
    check("full_after_5", full_o, 1);

    // ordering
    for (int k = 0; k < 4; k++) begin
      check("ord_req", rd_req, 1);
      check("ord_addr", rd_addr, 10'h10 + 10'(k));
      rd_gnt = 1'b1;
      tick();
      rd_gnt = 1'b0;
      check("ord_full_clear", full_o, 0);
      rd_valid = 1'b1; rd_data = 32'h110 + 32'(k);
      tick();
      rd_valid = 1'b0;
      check("ord_data", bram_rddata, 32'h110 + 32'(k));
      check("ord_rdvalid", bram_rdvalid, 1);
    end
    check("dropped_no_req", rd_req, 0);

    // simultaneous push and pop
    push_rd(10'h20);
    push_rd(10'h21);
    check("pp_head", rd_addr, 10'h20);
    bram_en = 1'b1; bram_addr = 10'h22; rd_gnt = 1'b1;
    tick();
    bram_en = 1'b0; rd_gnt = 1'b0;
    check("pp_full", full_o, 0);
    rd_valid = 1'b1; rd_data = 32'h220;
    tick();
    rd_valid = 1'b0;
    check("pp_data0", bram_rddata, 32'h220);
    for (int k = 1; k < 3; k++) begin
      check("pp_addr", rd_addr, 10'h20 + 10'(k));
      rd_gnt = 1'b1;
      tick();
      rd_gnt = 1'b0;
      rd_valid = 1'b1; rd_data = 32'h220 + 32'(k);
      tick();
      rd_valid = 1'b0;
      check("pp_data", bram_rddata, 32'h220 + 32'(k));
    end
    check("pp_drained", rd_req, 0);

    // unsolicited data
    rd_valid = 1'b1; rd_data = 32'hDEAD;
    tick();
    rd_valid = 1'b0;
    check("err_set", err_o, 1);
    check("err_no_rdvalid", bram_rdvalid, 0);
    check("err_data_ignored", bram_rddata, 32'h222);
    tick();
    check("err_sticky", err_o, 1);

    // reset in WAIT with three queued reads
    push_rd(10'h30);
    rd_gnt = 1'b1;
    tick();
    rd_gnt = 1'b0;
    push_rd(10'h31);
    push_rd(10'h32);
    push_rd(10'h33);
    rst_n = 1'b0;
    #2;
    check("mid_rst_full", full_o, 0);
    check("mid_rst_err", err_o, 0);
    check("mid_rst_data", bram_rddata, 0);
    check("mid_rst_req", rd_req, 0);
    check("mid_rst_addr", rd_addr, 0);
    check("mid_rst_done", done_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_req", rd_req, 0);
    check("post_rst_addr", rd_addr, 0);
    rd_valid = 1'b1; rd_data = 32'h330;
    tick();
    rd_valid = 1'b0;
    check("late_valid_err", err_o, 1);
    check("late_valid_no_rdvalid", bram_rdvalid, 0);
    push_rd(10'h40);
    check("new_req", rd_req, 1);
    check("new_addr", rd_addr, 10'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
